scope_trigger_seq: RTL and testbench
====================================

// Module: scope_trigger_seq
// PURPOSE
//  Parametrised multi-channel, multi-stage scope trigger.
//  - Synchronises NSIG inputs and evaluates per-channel level/edge conditions.
//  - Combines each stage's conditions by OR or AND, and steps through NSTAGE sequential stages.
//  - Emits a one-cycle trigger pulse, then enforces a programmable holdoff.
//  - Sits between the input capture pins and the scope acquisition/RAM controller.
// PARAMETERS
//  NSIG   4   number of input signals
//  NSTAGE 2   number of sequential trigger stages (>=1)
//  HOLDW  16  width of holdoff counter
//  (derived) CW=3*NSIG+1 conf bits per stage; STW=max(1,$clog2(NSTAGE))
// PORTS
//  clk       in   1          single clock; all logic on posedge
//  rst       in   1          synchronous, active-high reset
//  sig       in   NSIG       asynchronous inputs
//  arm       in   1          pulse: arm the sequencer (from IDLE only)
//  disarm    in   1          pulse: abort to IDLE from any state
//  cont      in   1          1 = re-arm automatically after holdoff
//  conf      in   NSTAGE*CW  stage k = conf[k*CW +: CW]; ch i = [3i+:2] mode, [3i+2] val; bit 3*NSIG = AND
//  holdoff   in   HOLDW      holdoff length in cycles (latched on arm)
//  triggered out  1          one-cycle pulse when the final stage matches
//  armed     out  1          high while in ARMED
//  stage     out  STW        current stage index
//  changed   out  1          some synchronised input changed
//  sigout    out  NSIG       synchronised input copy
// BEHAVIOUR
//  Sync: per channel, 2-bit shift s <= {s[0],sig[i]}. s[0] is the current value; s[1] is the previous value.
//  Modes: 0 NONE (never matches), 1 LEVEL (s[0]==val), 2 EDGE (val=1: s==01 rise, val=0: s==10 fall),
//    3 ANY-EDGE (s[1]!=s[0], val ignored).
//  Stage match:
//    - OR: any channel matches.
//    - AND: all channels whose mode!=NONE match.
//    - A stage with all channels NONE never matches, in either combine mode.
//  conf and holdoff are copied into internal registers on each accepted arm, including a continuous re-arm.
//    Live changes while armed have no effect.
//  FSM:
//    IDLE    --arm-->          ARMED, stage=0
//    ARMED   --match(k), k<NSTAGE-1--> stage=k+1 (next stage evaluated from the following cycle;
//                                      at most one advance per cycle)
//    ARMED   --match(NSTAGE-1)-->      HOLDOFF, cnt=holdoff, triggered=1 for that one cycle
//    HOLDOFF: if cnt==0 then (cont ? ARMED stage=0 with fresh latch : IDLE), else cnt<=cnt-1.
//      holdoff=0 therefore gives one cycle in HOLDOFF; holdoff=N gives N+1 cycles.
//  Priority: rst > disarm > all else.
//    - disarm forces IDLE, stage=0, cnt=0; arm in the same cycle is ignored.
//    - arm in ARMED or HOLDOFF is ignored (no restart).
//  Latency: sig stable new value sampled into s[0] at edge E0; triggered is high in the cycle following E1.
//  changed <= |(s[1]^s[0]); sigout <= s[0]. Both registered, one cycle after s.
//  stage: holds 0 in IDLE and HOLDOFF; reports the current stage in ARMED.
//  Reset: s=0, FSM=IDLE, stage=0, cnt=0, latched conf=0, triggered=0, armed=0, changed=0, sigout=0.
//    Reset mid-sequence or mid-holdoff returns to IDLE with no trigger pulse.
// TESTING
//  1. NSIG=4, NSTAGE=1: stage0 ch0 EDGE val=1, OR; arm; sig[0] 0->1.
//     -> triggered one cycle, 2 edges after sampling; armed drops.
//  2. NSTAGE=2: stage0 ch1 LEVEL val=1; stage1 ch2 EDGE val=0; arm; raise sig[1], then fall sig[2].
//     -> stage 0->1, then triggered. Falling sig[2] before stage==1 must not trigger.
//  3. AND mode: ch0 LEVEL 1, ch3 LEVEL 0, others NONE. Apply sig=4'b1001: no trigger.
//     Then sig=4'b0001: trigger. Also an all-NONE stage never triggers.
//  4. holdoff=3, cont=1: repeated rising edges on ch0 every cycle.
//     -> triggered pulses exactly 5 cycles apart (1 trigger + 4 holdoff).
//     With cont=0: a single pulse, then IDLE.
//  5. Asserting arm and disarm in the same cycle -> stays IDLE.
//     Asserting disarm while stage==1 -> IDLE, stage=0.
//     Changing conf while ARMED -> no effect until the next arm.
//  6. Assert rst during HOLDOFF and during ARMED stage 1 -> all outputs 0 the next cycle and no trigger pulse.
//     Toggling sig[2] -> changed pulses for one cycle per toggle.

Source files
------------

// File: rtl/scope_trigger_seq.sv
// Multi-channel, multi-stage scope trigger: synchronised level/edge conditions,
// OR/AND combine per stage, sequential stages, one-cycle trigger pulse and holdoff.
module scope_trigger_seq #(
    parameter int NSIG   = 4,
    parameter int NSTAGE = 2,
    parameter int HOLDW  = 16,
    localparam int CW    = 3*NSIG + 1,
    localparam int STW   = (NSTAGE > 1) ? $clog2(NSTAGE) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NSIG-1:0]      sig,
    input  logic                 arm,
    input  logic                 disarm,
    input  logic                 cont,
    input  logic [NSTAGE*CW-1:0] conf,
    input  logic [HOLDW-1:0]     holdoff,
    output logic                 triggered,
    output logic                 armed,
    output logic [STW-1:0]       stage,
    output logic                 changed,
    output logic [NSIG-1:0]      sigout
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam logic [STW-1:0] LAST_STAGE = STW'(NSTAGE - 1);

    logic [NSIG-1:0]      cur;
    logic [NSIG-1:0]      prev;
    logic [NSIG-1:0]      ch_match;
    logic [NSIG-1:0]      ch_active;
    logic [CW-1:0]        stage_conf;
    logic                 and_mode;
    logic                 stage_match;

    state_t               state_reg, state_next;
    logic [STW-1:0]       stage_reg, stage_next;
    logic [HOLDW-1:0]     cnt_reg, cnt_next;
    logic [NSTAGE*CW-1:0] conf_reg;
    logic [HOLDW-1:0]     hold_reg;
    logic                 triggered_reg, triggered_next;
    logic                 load_next;
    logic                 changed_reg;
    logic [NSIG-1:0]      sigout_reg;

    // Input capture: s[0] is the current sample, s[1] the one before it.
    genvar gi;
    generate
        for (gi = 0; gi < NSIG; gi++) begin : g_sync
            logic [1:0] s_reg;
            always_ff @(posedge clk) begin
                if (rst) s_reg <= '0;
                else     s_reg <= {s_reg[0], sig[gi]};
            end
            assign cur[gi]  = s_reg[0];
            assign prev[gi] = s_reg[1];
        end
    endgenerate

    assign stage_conf = conf_reg[int'(stage_reg)*CW +: CW];
    assign and_mode   = stage_conf[CW-1];

    generate
        for (gi = 0; gi < NSIG; gi++) begin : g_cond
            logic [1:0] mode;
            logic       val;
            assign mode          = stage_conf[3*gi +: 2];
            assign val           = stage_conf[3*gi + 2];
            assign ch_active[gi] = (mode != 2'd0);
            assign ch_match[gi]  = (mode == 2'd1) ? (cur[gi] == val) :
                                   (mode == 2'd2) ? (val ? (~prev[gi] & cur[gi])
                                                         : (prev[gi] & ~cur[gi])) :
                                   (mode == 2'd3) ? (prev[gi] ^ cur[gi]) : 1'b0;
        end
    endgenerate

    // A stage with no active channel never matches, even when AND-combined.
    assign stage_match = (|ch_active) &
                         (and_mode ? &(ch_match | ~ch_active) : |ch_match);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            stage_reg     <= '0;
            cnt_reg       <= '0;
            conf_reg      <= '0;
            hold_reg      <= '0;
            triggered_reg <= 1'b0;
            changed_reg   <= 1'b0;
            sigout_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            stage_reg     <= stage_next;
            cnt_reg       <= cnt_next;
            triggered_reg <= triggered_next;
            changed_reg   <= |(prev ^ cur);
            sigout_reg    <= cur;
            if (load_next) begin
                conf_reg <= conf;
                hold_reg <= holdoff;
            end
        end
    end

    always_comb begin
        state_next     = state_reg;
        stage_next     = stage_reg;
        cnt_next       = cnt_reg;
        triggered_next = 1'b0;
        load_next      = 1'b0;
        if (disarm) begin
            state_next = ST_IDLE;
            stage_next = '0;
            cnt_next   = '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (arm) begin
                        state_next = ST_ARMED;
                        stage_next = '0;
                        load_next  = 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (stage_match) begin
                        if (stage_reg == LAST_STAGE) begin
                            state_next     = ST_HOLD;
                            stage_next     = '0;
                            cnt_next       = hold_reg;
                            triggered_next = 1'b1;
                        end else begin
                            stage_next = stage_reg + STW'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (cnt_reg == '0) begin
                        // Continuous mode re-latches conf/holdoff exactly like a fresh arm.
                        if (cont) begin
                            state_next = ST_ARMED;
                            stage_next = '0;
                            load_next  = 1'b1;
                        end else begin
                            state_next = ST_IDLE;
                        end
                    end else begin
                        cnt_next = cnt_reg - HOLDW'(1);
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    stage_next = '0;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    always_comb begin
        armed     = (state_reg == ST_ARMED);
        stage     = armed ? stage_reg : '0;
        triggered = triggered_reg;
        changed   = changed_reg;
        sigout    = sigout_reg;
    end

endmodule

// File: tb/tb_scope_trigger_seq.sv
// Directed bench for scope_trigger_seq: a two-stage and a single-stage instance,
// trigger pulses checked against scoreboard queues of expected cycle numbers.
module tb_scope_trigger_seq;

    localparam int CW = 13;
    localparam logic [CW-1:0] ANDB = 13'h1000;

    logic              clk = 1'b0;
    logic              rst;
    logic [3:0]        sig;
    logic              arm, arm1, disarm, cont;
    logic [2*CW-1:0]   conf;
    logic [CW-1:0]     conf1;
    logic [15:0]       holdoff;
    logic              triggered, armed, changed;
    logic [0:0]        stage;
    logic [3:0]        sigout;
    logic              triggered1, armed1, changed1;
    logic [0:0]        stage1;
    logic [3:0]        sigout1;

    int                vectors = 0;
    int                miscompares = 0;
    logic [31:0]       cyc = 0;
    logic [31:0]       exp_q[$];
    logic [31:0]       exp_q1[$];
    logic [31:0]       c;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    scope_trigger_seq #(.NSIG(4), .NSTAGE(2), .HOLDW(16)) dut (
        .clk(clk), .rst(rst), .sig(sig), .arm(arm), .disarm(disarm), .cont(cont),
        .conf(conf), .holdoff(holdoff), .triggered(triggered), .armed(armed),
        .stage(stage), .changed(changed), .sigout(sigout)
    );

    scope_trigger_seq #(.NSIG(4), .NSTAGE(1), .HOLDW(16)) dut1 (
        .clk(clk), .rst(rst), .sig(sig), .arm(arm1), .disarm(disarm), .cont(cont),
        .conf(conf1), .holdoff(holdoff), .triggered(triggered1), .armed(armed1),
        .stage(stage1), .changed(changed1), .sigout(sigout1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [CW-1:0] ch(input int i, input logic [1:0] mode, input logic val);
        logic [CW-1:0] r;
        r = '0;
        r[3*i +: 2] = mode;
        r[3*i + 2]  = val;
        return r;
    endfunction

    // Every trigger pulse must land on the next expected cycle.
    always @(negedge clk) begin
        logic [31:0] e;
        if (triggered) begin
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else                  e = 32'hFFFF_FFFF;
            chk("trig_cycle_main", cyc, e);
        end
        if (triggered1) begin
            if (exp_q1.size() > 0) e = exp_q1.pop_front();
            else                   e = 32'hFFFF_FFFF;
            chk("trig_cycle_single", cyc, e);
        end
    end

    initial begin
        rst = 1'b1; sig = '0; arm = 0; arm1 = 0; disarm = 0; cont = 0;
        conf = '0; conf1 = '0; holdoff = '0;
        tick(3);
        chk("rst_triggered", {31'd0, triggered}, 0);
        chk("rst_armed", {31'd0, armed}, 0);
        chk("rst_stage", {31'd0, stage}, 0);
        chk("rst_changed", {31'd0, changed}, 0);
        chk("rst_sigout", {28'd0, sigout}, 0);
        chk("rst_armed1", {31'd0, armed1}, 0);
        rst = 1'b0;
        tick(2);

        // 1: single stage, rising edge on ch0
        conf1 = ch(0, 2'd2, 1'b1);
        arm1 = 1; tick(); arm1 = 0;
        chk("t1_armed", {31'd0, armed1}, 1);
        sig[0] = 1'b1; exp_q1.push_back(cyc + 2);
        tick();
        chk("t1_no_trig_yet", {31'd0, triggered1}, 0);
        tick();
        chk("t1_trig", {31'd0, triggered1}, 1);
        chk("t1_disarmed", {31'd0, armed1}, 0);
        tick();
        chk("t1_pulse_end", {31'd0, triggered1}, 0);
        sig = '0; tick(3);

        // 2: stage0 level ch1, stage1 falling ch2
        conf = {ch(2, 2'd2, 1'b0), ch(1, 2'd1, 1'b1)};
        sig = 4'b0100; tick(2);
        arm = 1; tick(); arm = 0;
        chk("t2_armed", {31'd0, armed}, 1);
        chk("t2_stage0", {31'd0, stage}, 0);
        sig[2] = 1'b0; tick(3);
        chk("t2_early_fall_stage", {31'd0, stage}, 0);
        sig[2] = 1'b1; tick(2);
        sig[1] = 1'b1; tick(2);
        chk("t2_stage1", {31'd0, stage}, 1);
        sig[2] = 1'b0; exp_q.push_back(cyc + 2);
        tick(2);
        chk("t2_armed_drop", {31'd0, armed}, 0);
        tick(3);
        chk("t2_pending", exp_q.size(), 0);
        sig = '0; tick(2);

        // 3: AND combine, same condition in both stages
        conf = {ANDB | ch(0, 2'd1, 1'b1) | ch(3, 2'd1, 1'b0),
                ANDB | ch(0, 2'd1, 1'b1) | ch(3, 2'd1, 1'b0)};
        arm = 1; tick(); arm = 0;
        sig = 4'b1001; tick(4);
        chk("t3_and_partial", {31'd0, armed}, 1);
        chk("t3_and_stage", {31'd0, stage}, 0);
        sig = 4'b0001; exp_q.push_back(cyc + 3);
        tick(3);
        chk("t3_and_done", {31'd0, armed}, 0);
        tick(2);
        chk("t3_pending", exp_q.size(), 0);
        sig = '0; tick(2);
        for (int k = 0; k < 2; k++) begin
            conf = (k == 0) ? {13'd0, ANDB} : '0;
            arm = 1; tick(); arm = 0;
            for (int j = 0; j < 8; j++) begin
                sig = 4'($urandom);
                tick();
            end
            chk("t3_none_armed", {31'd0, armed}, 1);
            chk("t3_none_stage", {31'd0, stage}, 0);
            disarm = 1; tick(); disarm = 0;
        end
        sig = '0; tick(2);

        // 4: single stage, any edge on ch0 every cycle, holdoff 3, continuous
        conf1 = ch(0, 2'd3, 1'b0); holdoff = 16'd3; cont = 1;
        for (int j = 0; j < 4; j++) begin
            sig[0] = ~sig[0]; tick();
        end
        arm1 = 1;
        c = cyc;
        exp_q1.push_back(c + 2); exp_q1.push_back(c + 7); exp_q1.push_back(c + 12);
        for (int j = 0; j < 20; j++) begin
            sig[0] = ~sig[0];
            tick();
            arm1 = 0;
            if (j == 11) cont = 0;
        end
        chk("t4_idle", {31'd0, armed1}, 0);
        chk("t4_pending", exp_q1.size(), 0);
        sig = '0; tick(2);

        // 5: arm+disarm together, disarm in stage 1, live conf change
        holdoff = '0;
        arm = 1; disarm = 1; tick(); arm = 0; disarm = 0;
        chk("t5_arm_disarm", {31'd0, armed}, 0);
        tick();
        chk("t5_arm_disarm_2", {31'd0, armed}, 0);
        conf = {ch(2, 2'd2, 1'b0), ch(1, 2'd1, 1'b1)};
        sig = 4'b0100; tick(2);
        arm = 1; tick(); arm = 0;
        sig[1] = 1'b1; tick(2);
        chk("t5_stage1", {31'd0, stage}, 1);
        disarm = 1; tick(); disarm = 0;
        chk("t5_disarm_armed", {31'd0, armed}, 0);
        chk("t5_disarm_stage", {31'd0, stage}, 0);
        sig[2] = 1'b0; tick(3);
        sig = '0; tick(2);
        conf = {ch(3, 2'd1, 1'b1), ch(3, 2'd1, 1'b1)};
        arm = 1; tick(); arm = 0;
        conf = {ch(0, 2'd1, 1'b1), ch(0, 2'd1, 1'b1)};
        sig[0] = 1'b1; tick(4);
        chk("t5_live_conf_ignored", {31'd0, armed}, 1);
        sig = 4'b1000; exp_q.push_back(cyc + 3);
        tick(4);
        chk("t5_latched_trig", exp_q.size(), 0);
        sig = '0; tick(2);
        arm = 1; tick(); arm = 0;
        sig[0] = 1'b1; exp_q.push_back(cyc + 3);
        tick(4);
        chk("t5_new_conf_trig", exp_q.size(), 0);
        sig = '0; tick(2);

        // 6: reset during holdoff and during stage 1; changed pulses
        conf = {ch(0, 2'd1, 1'b1), ch(0, 2'd1, 1'b1)}; holdoff = 16'd10;
        arm = 1; tick(); arm = 0;
        sig[0] = 1'b1; exp_q.push_back(cyc + 3);
        tick(5);
        rst = 1; tick(); rst = 0;
        chk("t6_hold_rst_armed", {31'd0, armed}, 0);
        chk("t6_hold_rst_trig", {31'd0, triggered}, 0);
        chk("t6_hold_rst_sigout", {28'd0, sigout}, 0);
        chk("t6_hold_rst_changed", {31'd0, changed}, 0);
        sig = '0; tick(12);
        chk("t6_hold_rst_idle", {31'd0, armed}, 0);
        conf = {ch(1, 2'd1, 1'b1), ch(0, 2'd1, 1'b1)};
        arm = 1; tick(); arm = 0;
        sig[0] = 1'b1; tick(2);
        chk("t6_stage1", {31'd0, stage}, 1);
        sig[1] = 1'b1; rst = 1; tick();
        chk("t6_arm_rst_armed", {31'd0, armed}, 0);
        chk("t6_arm_rst_stage", {31'd0, stage}, 0);
        chk("t6_arm_rst_trig", {31'd0, triggered}, 0);
        tick(); rst = 0;
        tick(3);
        chk("t6_after_rst_idle", {31'd0, armed}, 0);
        sig = '0; tick(3);
        for (int k = 0; k < 2; k++) begin
            sig[2] = ~sig[2];
            tick();
            chk("t6_changed_pre", {31'd0, changed}, 0);
            tick();
            chk("t6_changed_pulse", {31'd0, changed}, 1);
            chk("t6_sigout", {28'd0, sigout}, (k == 0) ? 32'h4 : 32'h0);
            tick();
            chk("t6_changed_post", {31'd0, changed}, 0);
        end

        chk("final_pending_main", exp_q.size(), 0);
        chk("final_pending_single", exp_q1.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
